// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scanout slice.
//   - 800x600@72 timing defaults (visible, porches, sync widths, polarities)
//   - derived default H_TOTAL / V_TOTAL
//   - bit positions of the R/G/B fields inside a 12-bit 4:4:4 colour word
//   - the raster-flag bundle carried through the read-latency delay line
//   - the colour generator for the built-in bar pattern
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_VISIBLE  = 800;
    localparam int DEF_H_FRONT    = 56;
    localparam int DEF_H_SYNC     = 120;
    localparam int DEF_H_BACK     = 64;
    localparam int DEF_V_VISIBLE  = 600;
    localparam int DEF_V_FRONT    = 37;
    localparam int DEF_V_SYNC     = 6;
    localparam int DEF_V_BACK     = 23;
    localparam bit DEF_H_POL      = 1'b1;
    localparam bit DEF_V_POL      = 1'b1;
    localparam int DEF_PIX_DIV    = 2;
    localparam int DEF_RD_LATENCY = 1;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } raster_flags_t;

    // Bar i lights each colour channel fully when the matching index bit is
    // set, giving black at bar 0 through white at bar 7.
    function automatic logic [11:0] bar_colour(input logic [2:0] bar);
        return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Register chain of DEPTH stages, WIDTH bits wide, with synchronous reset to
// zero. DEPTH = 0 is a straight wire.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset (clears every stage)
//   din  - value entering the chain
//   dout - value after DEPTH clk cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
// Raster timing generator and pixel reader. Sweeps x/y as frame buffer read
// coordinates, realigns the blanking/sync decode with the returning colour,
// and drives registered sync and 4:4:4 RGB to the connector.
// Optional feature: define VGA_TEST_PATTERN_EN to replace colour_in with a
// built-in 8-bar pattern (bar index x[9:7]); sync/blanking are unchanged.
// Ports:
//   clk        - system clock (pixel rate is clk / PIX_DIV)
//   rst        - synchronous, active-high reset
//   x, y       - raw raster counters, used as frame buffer read column/row
//   colour_in  - frame buffer read data {R[11:8], G[7:4], B[3:0]}
//   frame_trig - one-clk pulse on the step into the first blanking line
//   hsync      - registered horizontal sync
//   vsync      - registered vertical sync
//   vga_r/g/b  - registered 4-bit colour channels
// -----------------------------------------------------------------------------
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_POL      = DEF_H_POL,
    parameter bit V_POL      = DEF_V_POL,
    parameter int PIX_DIV    = DEF_PIX_DIV,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [9:0]  y,
    input  logic [11:0] colour_in,
    output logic        frame_trig,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_TRIG     = 10'(V_VISIBLE - 1);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [2:0]  DIV_LAST   = 3'(PIX_DIV - 1);

    logic [2:0]    div;
    logic          pix_en;
    raster_flags_t flags_now;
    raster_flags_t flags_d;
    logic [11:0]   colour_sel;

    assign pix_en = (div == DIV_LAST);

    // Pixel divider and raster counters. x/y move once per pixel and are
    // left raw through blanking; the colour mask makes those reads harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            x   <= '0;
            y   <= '0;
        end else if (pix_en) begin
            div <= '0;
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 10'd1;
            end else begin
                x <= x + 11'd1;
            end
        end else begin
            div <= div + 3'd1;
        end
    end

    // Pulse on the exact step from the last visible line into blanking.
    assign frame_trig = pix_en && (x == X_LAST) && (y == Y_TRIG);

    always_comb begin
        flags_now        = '0;
        flags_now.active = (x < 11'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
        flags_now.hs     = (x >= HS_START) && (x < HS_END);
        flags_now.vs     = (y >= VS_START) && (y < VS_END);
    end

`ifdef VGA_TEST_PATTERN_EN
    // The bar index rides the same delay line as the flags so the pattern
    // stays locked to the blanking decode.
    logic [2:0] bar_d;
    logic       unused_colour_in;

    assign unused_colour_in = ^colour_in;

    vga_delay_line #(
        .WIDTH (6),
        .DEPTH (RD_LATENCY)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  ({x[9:7], flags_now}),
        .dout ({bar_d, flags_d})
    );

    assign colour_sel = bar_colour(bar_d);
`else
    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (RD_LATENCY)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  (flags_now),
        .dout (flags_d)
    );

    assign colour_sel = colour_in;
`endif

    // Pin register: sync polarity applied here, colour blanked outside the
    // active region.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= flags_d.hs ? H_POL : ~H_POL;
            vsync <= flags_d.vs ? V_POL : ~V_POL;
            vga_r <= flags_d.active ? colour_sel[R_HI:R_LO] : 4'h0;
            vga_g <= flags_d.active ? colour_sel[G_HI:G_LO] : 4'h0;
            vga_b <= flags_d.active ? colour_sel[B_HI:B_LO] : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
// Self-checking bench for vga_scanout using a shrunken raster so several whole
// frames fit in a short run. A reference model derives the expected raster
// position and pin values from the number of clk edges since reset, using
// plain division/modulo arithmetic. A frame buffer model with 1-clk latency
// feeds colour_in from the DUT's read coordinates.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

    localparam int HV = 10, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
    localparam int D  = 2;
    localparam int L  = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] colour_in = 12'h000;
    logic        frame_trig;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    int          total = 0;
    int          bad   = 0;
    int          k     = 0;
    int          last_trig = 0;
    bit          have_trig = 1'b0;
    int          fb_mode   = 0;
    logic [11:0] key       = 12'h000;

    vga_scanout #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .H_POL (HP), .V_POL (VP), .PIX_DIV (D), .RD_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .colour_in  (colour_in),
        .frame_trig (frame_trig),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #5 clk = ~clk;

    // Frame buffer contents: coordinate-tagged data scrambled by a run key,
    // or a flat colour.
    function automatic logic [11:0] fbColour(input int xx, input int yy);
        logic [3:0] xl;
        logic [3:0] yl;
        xl = 4'(xx);
        yl = 4'(yy);
        if (fb_mode == 1) return 12'hABC;
        return {xl ^ key[3:0], yl ^ key[7:4], key[11:8]};
    endfunction

    // Frame buffer read port with one clk of latency.
    always @(posedge clk) begin
        colour_in <= fbColour(int'(x), int'(y));
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at k=%0d: got=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Expected raster position after n post-reset clk edges.
    task automatic rasterPos(input int n, output int xx, output int yy);
        int p;
        p  = n / D;
        xx = p % HT;
        yy = (p / HT) % VT;
    endtask

    task automatic checkCycle();
        int xx, yy, px, py, src;
        bit trig_exp, act;
        logic exp_hs, exp_vs;
        logic [11:0] exp_rgb;

        rasterPos(k, xx, yy);
        checkOutput("x", 32'(x), 32'(xx));
        checkOutput("y", 32'(y), 32'(yy));

        trig_exp = ((k % D) == D - 1) && (xx == HT - 1) && (yy == VV - 1);
        checkOutput("frame_trig", 32'(frame_trig), 32'(trig_exp));

        src     = k - L - 1;
        exp_hs  = ~HP;
        exp_vs  = ~VP;
        exp_rgb = 12'h000;
        if (src >= 0) begin
            rasterPos(src, px, py);
            act = (px < HV) && (py < VV);
            if ((px >= HV + HF) && (px < HV + HF + HS)) exp_hs = HP;
            if ((py >= VV + VF) && (py < VV + VF + VS)) exp_vs = VP;
`ifdef VGA_TEST_PATTERN_EN
            if (act) exp_rgb = {{4{px[9]}}, {4{px[8]}}, {4{px[7]}}};
`else
            if (act) exp_rgb = fbColour(px, py);
`endif
        end
        checkOutput("hsync", 32'(hsync), 32'(exp_hs));
        checkOutput("vsync", 32'(vsync), 32'(exp_vs));
        checkOutput("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));

        if (frame_trig) begin
            if (have_trig) checkOutput("trig_period", 32'(k - last_trig), 32'(FRAME_CLK));
            have_trig = 1'b1;
            last_trig = k;
        end
    endtask

    // Hold rst at r for n clk edges, checking the pins after every edge.
    task automatic applyStimulus(input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            rst = r;
            @(posedge clk);
            if (r) begin
                k         = 0;
                have_trig = 1'b0;
            end else begin
                k++;
            end
            #1;
            checkCycle();
        end
    endtask

    initial begin
        int trig_count;
        key     = 12'($urandom);
        fb_mode = 0;
        $display("[TB] start, colour key=%03h, frame=%0d clk", key, FRAME_CLK);

        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 3 * FRAME_CLK + 40);

        // Mid-frame resets at random positions and of random length.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, int'($urandom_range(3, 1)));
            applyStimulus(1'b0, int'($urandom_range(FRAME_CLK - 1, 50)));
        end
        applyStimulus(1'b1, 1);

        // Count frame triggers over two whole frames from a fresh reset.
        trig_count = 0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            applyStimulus(1'b0, 1);
            if (frame_trig) trig_count++;
        end
        checkOutput("trig_count", 32'(trig_count), 32'd2);

        // Flat colour from the frame buffer.
        fb_mode = 1;
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, FRAME_CLK + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
